// File: rtl/ahmes_pkg.sv
// Shared opcode and branch-condition encodings for the Ahmes datapath,
// plus the per-opcode flag update mask used by the accumulator/flag stage.
package ahmes_pkg;

  // ALU opcodes as carried alongside a commit
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADIC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OU   = 4'b0011;
  localparam logic [3:0] OP_E    = 4'b0100;
  localparam logic [3:0] OP_NAO  = 4'b0101;
  localparam logic [3:0] OP_DLE  = 4'b0110;
  localparam logic [3:0] OP_DLD  = 4'b0111;
  localparam logic [3:0] OP_DAE  = 4'b1000;
  localparam logic [3:0] OP_DAD  = 4'b1001;

  // Branch condition codes
  localparam logic [3:0] COND_JMP = 4'b0000;
  localparam logic [3:0] COND_JN  = 4'b0001;
  localparam logic [3:0] COND_JP  = 4'b0010;
  localparam logic [3:0] COND_JV  = 4'b0011;
  localparam logic [3:0] COND_JNV = 4'b0100;
  localparam logic [3:0] COND_JZ  = 4'b0101;
  localparam logic [3:0] COND_JNZ = 4'b0110;
  localparam logic [3:0] COND_JC  = 4'b0111;
  localparam logic [3:0] COND_JNC = 4'b1000;
  localparam logic [3:0] COND_JB  = 4'b1001;
  localparam logic [3:0] COND_JNB = 4'b1010;

  // Bit positions inside the packed {N,Z,C,B,V} flag vector
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_B = 1;
  localparam int FLAG_V = 0;

  localparam logic [4:0] FLAGS_RESET = 5'b01000;

  typedef logic [4:0] flags_t;

  function automatic flags_t flag_mask(input logic [3:0] op);
    flags_t mask;
    mask = 5'b00000;
    case (op)
      OP_ADIC:                       mask = 5'b11101;
      OP_SUB:                        mask = 5'b11011;
      OP_OU, OP_E, OP_NAO:           mask = 5'b11000;
      OP_DLE, OP_DLD, OP_DAE, OP_DAD: mask = 5'b11100;
      default:                       mask = 5'b00000;
    endcase
    return mask;
  endfunction

  // Opcodes above DAD are unassigned and must not touch architectural state
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_DAD);
  endfunction

endpackage

// File: rtl/ahmes_acc_flags_if.sv
// Bundle between the ALU/control unit and the accumulator/flag stage:
// commit bus, direct load path, branch query handshake and state readback.
interface ahmes_acc_flags_if #(
  parameter int W = 8
);

  logic         commit_valid;
  logic [3:0]   operacao;
  logic [W-1:0] alu_result;
  logic         alu_n;
  logic         alu_z;
  logic         alu_c;
  logic         alu_b;
  logic         alu_v;
  logic         load_ac;
  logic [W-1:0] ld_data;
  logic         cond_req;
  logic [3:0]   cond;

  logic [W-1:0] ac;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_b;
  logic         flag_v;
  logic         alu_cin;
  logic         cond_ack;
  logic         cond_taken;
  logic         err;

  modport master (
    output commit_valid, operacao, alu_result,
    output alu_n, alu_z, alu_c, alu_b, alu_v,
    output load_ac, ld_data, cond_req, cond,
    input  ac, flag_n, flag_z, flag_c, flag_b, flag_v,
    input  alu_cin, cond_ack, cond_taken, err
  );

  modport slave (
    input  commit_valid, operacao, alu_result,
    input  alu_n, alu_z, alu_c, alu_b, alu_v,
    input  load_ac, ld_data, cond_req, cond,
    output ac, flag_n, flag_z, flag_c, flag_b, flag_v,
    output alu_cin, cond_ack, cond_taken, err
  );

endinterface

// File: rtl/ahmes_cond_eval.sv
// Combinational branch-condition decoder: maps a condition code and a flag
// set to a taken decision, flagging codes outside JMP..JNB as illegal.
module ahmes_cond_eval
  import ahmes_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       b,
  input  logic       v,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_JMP: taken = 1'b1;
      COND_JN:  taken = n;
      COND_JP:  taken = ~n & ~z;
      COND_JV:  taken = v;
      COND_JNV: taken = ~v;
      COND_JZ:  taken = z;
      COND_JNZ: taken = ~z;
      COND_JC:  taken = c;
      COND_JNC: taken = ~c;
      COND_JB:  taken = b;
      COND_JNB: taken = ~b;
      default: begin
        taken   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahmes_acc_flags.sv
// Ahmes accumulator and N/Z/C/B/V flag register with masked ALU commits,
// direct AC load and a registered one-cycle branch-condition handshake.
module ahmes_acc_flags
  import ahmes_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ahmes_acc_flags_if.slave  bus
);

  logic [W-1:0] ac_d, ac_q;
  flags_t       flags_d, flags_q;
  logic         err_d, err_q;
  logic         cond_ack_d, cond_ack_q;
  logic         cond_taken_d, cond_taken_q;

  flags_t       alu_flags;
  flags_t       mask;
  logic         eval_taken;
  logic         eval_illegal;

  assign alu_flags = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_b, bus.alu_v};
  assign mask      = flag_mask(bus.operacao);

  // Next architectural state; a commit always takes priority over a load
  always_comb begin
    ac_d    = ac_q;
    flags_d = flags_q;
    err_d   = err_q;

    if (bus.commit_valid) begin
      if (op_illegal(bus.operacao)) begin
        err_d = 1'b1;
      end else if (bus.operacao != OP_NOP) begin
        ac_d    = bus.alu_result;
        flags_d = (flags_q & ~mask) | (alu_flags & mask);
      end
      if (bus.load_ac) begin
        err_d = 1'b1;
      end
    end else if (bus.load_ac) begin
      ac_d            = bus.ld_data;
      flags_d[FLAG_N] = bus.ld_data[W-1];
      flags_d[FLAG_Z] = (bus.ld_data == '0);
    end

    if (bus.cond_req && eval_illegal) begin
      err_d = 1'b1;
    end
  end

  // Evaluated on the bypassed next-state flags so a same-cycle commit counts
  ahmes_cond_eval u_cond_eval (
    .cond    (bus.cond),
    .n       (flags_d[FLAG_N]),
    .z       (flags_d[FLAG_Z]),
    .c       (flags_d[FLAG_C]),
    .b       (flags_d[FLAG_B]),
    .v       (flags_d[FLAG_V]),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  always_comb begin
    cond_ack_d   = bus.cond_req;
    cond_taken_d = bus.cond_req & eval_taken;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_q         <= '0;
      flags_q      <= FLAGS_RESET;
      err_q        <= 1'b0;
      cond_ack_q   <= 1'b0;
      cond_taken_q <= 1'b0;
    end else begin
      ac_q         <= ac_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
      cond_ack_q   <= cond_ack_d;
      cond_taken_q <= cond_taken_d;
    end
  end

  assign bus.ac         = ac_q;
  assign bus.flag_n     = flags_q[FLAG_N];
  assign bus.flag_z     = flags_q[FLAG_Z];
  assign bus.flag_c     = flags_q[FLAG_C];
  assign bus.flag_b     = flags_q[FLAG_B];
  assign bus.flag_v     = flags_q[FLAG_V];
  assign bus.alu_cin    = flags_q[FLAG_C];
  assign bus.cond_ack   = cond_ack_q;
  assign bus.cond_taken = cond_taken_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ahmes_acc_flags.sv
// Directed self-checking bench for ahmes_acc_flags; every expected value
// below is worked out by hand from the opcode masks and condition table.
module tb_ahmes_acc_flags;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ahmes_acc_flags_if #(.W(8)) bus ();

  ahmes_acc_flags #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.commit_valid = 1'b0;
    bus.operacao     = 4'h0;
    bus.alu_result   = 8'h00;
    bus.alu_n        = 1'b0;
    bus.alu_z        = 1'b0;
    bus.alu_c        = 1'b0;
    bus.alu_b        = 1'b0;
    bus.alu_v        = 1'b0;
    bus.load_ac      = 1'b0;
    bus.ld_data      = 8'h00;
    bus.cond_req     = 1'b0;
    bus.cond         = 4'h0;
  endtask

  task automatic apply_commit(input logic [3:0] op, input logic [7:0] res,
                              input logic [4:0] f);
    bus.commit_valid = 1'b1;
    bus.operacao     = op;
    bus.alu_result   = res;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_b, bus.alu_v} = f;
  endtask

  task automatic apply_query(input logic [3:0] c);
    bus.cond_req = 1'b1;
    bus.cond     = c;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_b, bus.flag_v};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();

    // Reset held two cycles while a commit and a query are presented
    rst_n = 1'b0;
    apply_commit(4'b0001, 8'h55, 5'b10111);
    apply_query(4'b0000);
    tick();
    tick();
    check_output("rst_ac", bus.ac, 8'h00);
    check_output("rst_flags", flags_now(), 5'b01000);
    check_output("rst_err", bus.err, 1'b0);
    check_output("rst_ack", bus.cond_ack, 1'b0);
    check_output("rst_taken", bus.cond_taken, 1'b0);
    check_output("rst_cin", bus.alu_cin, 1'b0);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    check_output("idle_ack", bus.cond_ack, 1'b0);

    // ADIC: N,Z,C,V taken from ALU, B masked off
    apply_commit(4'b0001, 8'h80, 5'b10011);
    tick();
    clear_inputs();
    check_output("adic_ac", bus.ac, 8'h80);
    check_output("adic_flags", flags_now(), 5'b10001);
    check_output("adic_err", bus.err, 1'b0);

    // DAE sets C; then E must leave C alone
    apply_commit(4'b1000, 8'hFE, 5'b10100);
    tick();
    clear_inputs();
    check_output("dae_ac", bus.ac, 8'hFE);
    check_output("dae_flags", flags_now(), 5'b10101);
    check_output("dae_cin", bus.alu_cin, 1'b1);
    apply_commit(4'b0100, 8'h00, 5'b01010);
    tick();
    clear_inputs();
    check_output("e_ac", bus.ac, 8'h00);
    check_output("e_flags", flags_now(), 5'b01101);
    check_output("e_cin", bus.alu_cin, 1'b1);

    // Load a non-zero value so Z=0, then SUB to zero with a same-cycle JZ
    bus.load_ac = 1'b1;
    bus.ld_data = 8'h05;
    tick();
    clear_inputs();
    check_output("ld05_flags", flags_now(), 5'b00101);
    apply_commit(4'b0010, 8'h00, 5'b01010);
    apply_query(4'b0101);
    tick();
    clear_inputs();
    check_output("byp_ack", bus.cond_ack, 1'b1);
    check_output("byp_taken", bus.cond_taken, 1'b1);
    check_output("sub_flags", flags_now(), 5'b01110);
    tick();
    check_output("byp_ack_drop", bus.cond_ack, 1'b0);
    check_output("byp_taken_drop", bus.cond_taken, 1'b0);

    // Back-to-back queries: JC taken (C=1), then JNC not taken
    apply_query(4'b0111);
    tick();
    check_output("b2b_ack1", bus.cond_ack, 1'b1);
    check_output("b2b_taken1", bus.cond_taken, 1'b1);
    apply_query(4'b1000);
    tick();
    clear_inputs();
    check_output("b2b_ack2", bus.cond_ack, 1'b1);
    check_output("b2b_taken2", bus.cond_taken, 1'b0);
    tick();
    check_output("b2b_ack3", bus.cond_ack, 1'b0);
    check_output("b2b_err", bus.err, 1'b0);

    // Commit and load together: commit wins, err sticks
    do_reset();
    apply_commit(4'b0001, 8'h11, 5'b00000);
    bus.load_ac = 1'b1;
    bus.ld_data = 8'h22;
    tick();
    clear_inputs();
    check_output("conf_ac", bus.ac, 8'h11);
    check_output("conf_flags", flags_now(), 5'b00000);
    check_output("conf_err", bus.err, 1'b1);
    tick();
    tick();
    check_output("conf_err_sticky", bus.err, 1'b1);

    // Illegal opcode: no state change, err set
    do_reset();
    check_output("rst2_err", bus.err, 1'b0);
    apply_commit(4'b1100, 8'h77, 5'b11111);
    tick();
    clear_inputs();
    check_output("illop_ac", bus.ac, 8'h00);
    check_output("illop_flags", flags_now(), 5'b01000);
    check_output("illop_err", bus.err, 1'b1);

    // Illegal condition code: ack still pulses, never taken
    do_reset();
    apply_query(4'b1111);
    tick();
    clear_inputs();
    check_output("illc_ack", bus.cond_ack, 1'b1);
    check_output("illc_taken", bus.cond_taken, 1'b0);
    check_output("illc_err", bus.err, 1'b1);

    // LDA path: set C via DAE, then load zero and query JP
    do_reset();
    apply_commit(4'b1000, 8'h01, 5'b00100);
    tick();
    clear_inputs();
    check_output("lda_pre_flags", flags_now(), 5'b00100);
    bus.load_ac = 1'b1;
    bus.ld_data = 8'h00;
    tick();
    clear_inputs();
    check_output("lda_ac", bus.ac, 8'h00);
    check_output("lda_flags", flags_now(), 5'b01100);
    apply_query(4'b0010);
    tick();
    clear_inputs();
    check_output("lda_jp_ack", bus.cond_ack, 1'b1);
    check_output("lda_jp_taken", bus.cond_taken, 1'b0);

    // Negative load bypassed into a same-cycle JN
    bus.load_ac = 1'b1;
    bus.ld_data = 8'h9A;
    apply_query(4'b0001);
    tick();
    clear_inputs();
    check_output("ld9a_ac", bus.ac, 8'h9A);
    check_output("ld9a_flags", flags_now(), 5'b10100);
    check_output("ld9a_jn_taken", bus.cond_taken, 1'b1);

    // NOP commit: nothing written even with all ALU flags high
    apply_commit(4'b0000, 8'hFF, 5'b11111);
    apply_query(4'b1001);
    tick();
    clear_inputs();
    check_output("nop_ac", bus.ac, 8'h9A);
    check_output("nop_flags", flags_now(), 5'b10100);
    check_output("nop_jb_taken", bus.cond_taken, 1'b0);
    check_output("nop_err", bus.err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
